coada_tx: RTL

Output buffer between `nucleu_enigma` and `uart_tx`. It accepts one 5-bit cipher index per `valid_in` pulse, stores it in a FIFO, and converts it to ASCII (`'A'`+index). It drives `uart_tx` with a start/done handshake, so back-to-back core outputs are never lost while the transmitter is busy. Optionally it inserts a space after every group of letters, giving classic 5-letter Enigma groups.

---
 rtl/pachet_enigma.sv | 7 +
 rtl/fifo_sincron.sv | 38 +++
 rtl/coada_tx.sv | 68 ++++++
 3 files changed

// File: rtl/pachet_enigma.sv
// pachet_enigma: shared constants and FSM state type for the Enigma output path
package pachet_enigma;
  localparam logic [7:0] ASCII_A = 8'd65;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int ALFABET = 26;
  typedef enum logic [1:0] {IDLE, SEND, WAIT} stare_t;
endpackage

// File: rtl/fifo_sincron.sv
// fifo_sincron: synchronous FIFO with wrap-bit pointers, full/empty flags and occupancy
module fifo_sincron #(
  parameter int DEPTH = 16,
  parameter int W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  logic wr, rd;
  assign rd = pop && !empty;
  assign wr = push && (!full || rd);
  assign level = wp - rp;
  assign full = level[AW];
  assign empty = wp == rp;
  assign dout = mem[rp[AW-1:0]];
  // pointers advance on accepted writes and reads; reset empties the queue
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
    end
  // storage array, no reset needed since pointers gate visibility
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/coada_tx.sv
// coada_tx: buffers cipher indices and feeds them as ASCII to uart_tx; COADA_TX_GRUPARE_EN adds spaces between letter groups
module coada_tx
  import pachet_enigma::*;
#(
  parameter int DEPTH = 16,
  parameter int GROUP_LEN = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   valid_in,
  input  logic [4:0]             char_in,
  input  logic                   tx_busy,
  input  logic                   tx_done,
  output logic                   tx_start,
  output logic [7:0]             tx_din,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("coada_tx: DEPTH must be a power of two >= 2");
  end
  if (GROUP_LEN < 1 || GROUP_LEN > 15) begin : g_bad_group
    $error("coada_tx: GROUP_LEN must be 1..15");
  end
  stare_t state;
  logic [4:0] head;
  logic push, pop, launch, space_due;
  assign push = valid_in && (char_in < 5'(ALFABET));
  assign launch = state == IDLE && !empty && !tx_busy;
  assign pop = launch && !space_due;
`ifdef COADA_TX_GRUPARE_EN
  logic [3:0] cnt;
  assign space_due = cnt == 4'(GROUP_LEN);
  // letters since the last space; cleared when the space is launched
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (launch) cnt <= space_due ? 4'd0 : cnt + 4'd1;
`else
  assign space_due = 1'b0;
`endif
  fifo_sincron #(.DEPTH(DEPTH), .W(5)) u_fifo (
    .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .din(char_in),
    .dout(head), .full(full), .empty(empty), .level(level)
  );
  // sticky flag for a valid letter lost because the FIFO was full and not draining
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) overflow <= 1'b0;
    else if (push && full && !pop) overflow <= 1'b1;
  // transmit sequencer: launch a byte from IDLE, then wait for the UART to finish it
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      tx_start <= 1'b0;
      tx_din <= 8'h00;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: if (launch) begin
          tx_start <= 1'b1;
          tx_din <= space_due ? ASCII_SPACE : ASCII_A + {3'b000, head};
          state <= space_due ? WAIT : SEND;
        end
        default: if (tx_done) state <= IDLE;
      endcase
    end
endmodule
